// File: rtl/fs_serial_sub.sv
// Bit-serial subtractor: DIFF = A - B - BIN, LSB first, one full-subtractor cell and a registered borrow.
// Optional signed-overflow output is enabled by defining FS_SERIAL_OVF_EN.
module fs_serial_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef FS_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, diff_nxt;
   logic [CW-1:0]    cnt;
   logic             br, br_nxt, d, ai, bi, accept, last;

   assign ai     = sa[0];
   assign bi     = sb[0];
   assign d      = ai ^ bi ^ br;
   assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
   assign last   = (cnt == CW'(WIDTH - 1));

   // New result bit enters at the MSB; for WIDTH=1 the register is just that bit.
   generate
      if (WIDTH == 1) begin : g_w1
         assign diff_nxt = d;
      end else begin : g_wn
         assign diff_nxt = {d, diff[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done   = 1'b1;
            accept = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Final borrow is registered on the last RUN edge so it is valid in the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
`ifdef FS_SERIAL_OVF_EN
         ovf  <= 1'b0;
`endif
      end else if (accept) begin
         sa  <= a;
         sb  <= b;
         br  <= bin;
         cnt <= '0;
      end else if (busy) begin
         sa   <= sa >> 1;
         sb   <= sb >> 1;
         br   <= br_nxt;
         diff <= diff_nxt;
         cnt  <= cnt + CW'(1);
         if (last) begin
            bout <= br_nxt;
`ifdef FS_SERIAL_OVF_EN
            ovf  <= br ^ br_nxt;
`endif
         end
      end
   end

endmodule
